// File: rtl/avalon_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_ram_if
//  Description : Avalon-MM bus bundle between the CPU (master) and the
//                program/data RAM (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface avalon_ram_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface
`default_nettype wire

// File: rtl/avalon_ram.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_ram
//  Description : Word-organised, byte-addressable RAM acting as Avalon-MM
//                slave, with a clock-free loader port for program preload
//                and a fixed-latency waitrequest handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module avalon_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int READ_WAIT   = 1,
    parameter int WRITE_WAIT  = 0
) (
    input  wire logic        clk,
    input  wire logic        RAM_Reset,
    avalon_ram_if.slave      bus,
    input  wire logic        inst_input,
    input  wire logic [7:0]  inst_addr,
    input  wire logic [31:0] instruction
);

    localparam int AW       = $clog2(DEPTH_WORDS);
    localparam int LDW      = (AW < 6) ? AW : 6;
    localparam int LD_WORDS = 1 << LDW;
    localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            op_wr_q, op_wr_d;
    logic [31:0]     readdata_q, readdata_d;

    // Each word has a clocked copy (CPU writes) and a latched copy (loader).
    // The XOR of the two per-word flags says which copy was written last.
    logic [31:0]            cpu_word_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] cpu_flag_q;
    logic [31:0]            ld_word    [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] ld_flag;

    logic [AW-1:0]  word_idx;
    logic [LDW-1:0] ld_idx;
    logic [31:0]    cur_word;
    logic [31:0]    merged_word;
    logic           req_active;
    logic           wait_fsm;
    logic           rd_comb;
    logic           wr_commit;
    logic           wr_en;
    logic           unused_bits;

    assign word_idx    = bus.address[AW+1:2];
    assign ld_idx      = inst_addr[LDW+1:2];
    assign cur_word    = (ld_flag[word_idx] ^ cpu_flag_q[word_idx]) ?
                         ld_word[word_idx] : cpu_word_q[word_idx];
    assign req_active  = op_wr_q ? bus.write : bus.read;
    assign wr_en       = wr_commit && (bus.byteenable != 4'b0000);
    assign unused_bits = ^{bus.address, inst_addr};

    // Loader storage: transparent while the loader targets the word, so a
    // program can be poked in without any clock activity.
    for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
        if (i < LD_WORDS) begin : g_ld
            logic [31:0] word_l;
            logic        flag_l;

            // Level-sensitive loader latch, cleared by reset.
            always_latch begin
                if (!RAM_Reset) begin
                    word_l = '0;
                    flag_l = 1'b0;
                end else if (inst_input && (ld_idx == LDW'(i))) begin
                    word_l = instruction;
                    flag_l = ~cpu_flag_q[i];
                end
            end

            assign ld_word[i] = word_l;
            assign ld_flag[i] = flag_l;
        end else begin : g_no_ld
            assign ld_word[i] = '0;
            assign ld_flag[i] = 1'b0;
        end
    end

    // Byte-lane merge of write data into the currently visible word.
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (bus.byteenable[b]) begin
                merged_word[8*b +: 8] = bus.writedata[8*b +: 8];
            end
        end
    end

    // Handshake next-state and outputs; loader activity stalls and restarts
    // any pending request so it completes against freshly loaded data.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        readdata_d = readdata_q;
        wait_fsm   = 1'b0;
        rd_comb    = 1'b0;
        wr_commit  = 1'b0;
        if (inst_input) begin
            wait_fsm = 1'b1;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.write) begin
                        op_wr_d = 1'b1;
                        if (WRITE_WAIT == 0) begin
                            wr_commit = 1'b1;
                        end else begin
                            wait_fsm = 1'b1;
                            if (WRITE_WAIT == 1) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_WAIT;
                                cnt_d   = CW'(WRITE_WAIT - 1);
                            end
                        end
                    end else if (bus.read) begin
                        op_wr_d = 1'b0;
                        if (READ_WAIT == 0) begin
                            rd_comb    = 1'b1;
                            readdata_d = cur_word;
                        end else begin
                            wait_fsm = 1'b1;
                            if (READ_WAIT == 1) begin
                                state_d    = ST_DONE;
                                readdata_d = cur_word;
                            end else begin
                                state_d = ST_WAIT;
                                cnt_d   = CW'(READ_WAIT - 1);
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req_active) begin
                        state_d = ST_IDLE;
                    end else begin
                        wait_fsm = 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_d = ST_DONE;
                            if (!op_wr_q) begin
                                readdata_d = cur_word;
                            end
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    if (req_active && op_wr_q) begin
                        wr_commit = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake state registers.
    always_ff @(posedge clk or negedge RAM_Reset) begin
        if (!RAM_Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            readdata_q <= readdata_d;
        end
    end

    // CPU write port: commits the merged word and marks the clocked copy
    // as the most recent one.
    always_ff @(posedge clk or negedge RAM_Reset) begin
        if (!RAM_Reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                cpu_word_q[i] <= '0;
            end
            cpu_flag_q <= '0;
        end else if (wr_en) begin
            cpu_word_q[word_idx] <= merged_word;
            cpu_flag_q[word_idx] <= ld_flag[word_idx];
        end
    end

    // Reset forces a quiet bus immediately, independent of the clock.
    assign bus.waitrequest = RAM_Reset & wait_fsm;
    assign bus.readdata    = !RAM_Reset ? 32'h0 :
                             (rd_comb ? cur_word : readdata_q);

endmodule
`default_nettype wire

// File: tb/tb_avalon_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_ram
//  Description : Self-checking bench for avalon_ram: directed loader,
//                handshake, byte-lane, stall and reset cases followed by
//                randomized traffic against an array-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_avalon_ram;

    localparam int RW = 1;
    localparam int WW = 2;

    logic        clk = 1'b0;
    logic        RAM_Reset;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic [31:0] instruction;

    avalon_ram_if bus ();

    avalon_ram #(
        .DEPTH_WORDS (256),
        .READ_WAIT   (RW),
        .WRITE_WAIT  (WW)
    ) dut (
        .clk         (clk),
        .RAM_Reset   (RAM_Reset),
        .bus         (bus),
        .inst_input  (inst_input),
        .inst_addr   (inst_addr),
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_m [256];
    logic [31:0] rd_last;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        rd_last = 32'h0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = mem_m[addr[9:2]];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_m[addr[9:2]] = w;
    endtask

    // Called at a negedge with a request already driven.
    task automatic wait_done(output logic [31:0] rdata, output int edges);
        logic done;
        done  = 1'b0;
        edges = 0;
        rdata = 32'h0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!bus.waitrequest) begin
                rdata = bus.readdata;
                @(posedge clk);
                edges++;
                done = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_eq("xfer_done", {31'b0, done}, 32'd1);
    endtask

    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output int edges);
        @(negedge clk);
        bus.address    = addr;
        bus.read       = rd;
        bus.write      = wr;
        bus.writedata  = wdata;
        bus.byteenable = be;
        wait_done(rdata, edges);
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic m_read(input string tag, input logic [31:0] addr);
        logic [31:0] d;
        logic [31:0] exp;
        int          e;
        exp = mem_m[addr[9:2]];
        xfer(1'b1, 1'b0, addr, $urandom, 4'hF, d, e);
        check_eq(tag, d, exp);
        check_eq({tag, "_lat"}, e, RW + 1);
        #1;
        check_eq({tag, "_hold"}, bus.readdata, exp);
        rd_last = exp;
    endtask

    task automatic m_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        int          e;
        xfer(1'b0, 1'b1, addr, d, be, r, e);
        check_eq("wr_lat", e, WW + 1);
        model_write(addr, d, be);
    endtask

    task automatic m_rdwr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        int          e;
        xfer(1'b1, 1'b1, addr, d, be, r, e);
        check_eq("rdwr_rdata", r, rd_last);
        check_eq("rdwr_lat", e, WW + 1);
        model_write(addr, d, be);
    endtask

    // Loads up to four words at 1-unit spacing, all between two clock edges.
    task automatic load_seq(input int n, input logic [7:0] a [4], input logic [31:0] d [4]);
        @(negedge clk);
        inst_input = 1'b1;
        for (int i = 0; i < n; i++) begin
            inst_addr   = a[i];
            instruction = d[i];
            mem_m[{2'b00, a[i][7:2]}] = d[i];
            #1;
        end
        inst_input = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  la [4];
        logic [31:0] ld [4];
        logic [31:0] r;
        logic [31:0] a;
        int          e;
        int          op;

        RAM_Reset      = 1'b0;
        inst_input     = 1'b0;
        inst_addr      = 8'h0;
        instruction    = 32'h0;
        bus.address    = 32'h0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = 32'h0;
        bus.byteenable = 4'h0;
        model_clear();

        #1;
        check_eq("rst_wait", {31'b0, bus.waitrequest}, 32'h0);
        check_eq("rst_rdata", bus.readdata, 32'h0);
        repeat (2) @(negedge clk);
        RAM_Reset = 1'b1;

        // Program preload through the loader port.
        la[0] = 8'h04; ld[0] = 32'h240300FF;
        la[1] = 8'h08; ld[1] = 32'h24040F0F;
        la[2] = 8'h0C; ld[2] = 32'h00641026;
        la[3] = 8'h10; ld[3] = 32'h00000008;
        load_seq(4, la, ld);
        check_eq("load_w1", mem_m[1], 32'h240300FF);
        m_read("ld_04", 32'h04);
        m_read("ld_08", 32'hBFC00008);
        m_read("ld_0c", 32'h0C);
        m_read("ld_10", 32'h10);
        m_read("ld_00", 32'h00);
        xfer(1'b1, 1'b0, 32'hBFC00008, 32'h0, 4'hF, r, e);
        check_eq("alias_rd", r, 32'h24040F0F);
        check_eq("alias_lat", e, 2);
        rd_last = 32'h24040F0F;

        // Byte-lane writes.
        m_write(32'h14, 32'h11223344, 4'hF);
        m_write(32'h14, 32'hAABBCCDD, 4'b0011);
        xfer(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, r, e);
        check_eq("be_0011", r, 32'h1122CCDD);
        m_write(32'h14, 32'h99000000, 4'b1000);
        xfer(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, r, e);
        check_eq("be_1000", r, 32'h9922CCDD);
        rd_last = 32'h9922CCDD;
        m_write(32'h14, 32'h55555555, 4'b0000);
        m_read("be_0000", 32'h14);

        // Read and write together behave as a write.
        m_rdwr(32'h18, 32'h0BADF00D, 4'hF);
        m_read("rdwr_after", 32'h18);

        // Master abandons a write while it is still waiting.
        @(negedge clk);
        bus.address = 32'h30; bus.writedata = 32'hDEADBEEF;
        bus.byteenable = 4'hF; bus.write = 1'b1;
        #1;
        check_eq("abort_wait1", {31'b0, bus.waitrequest}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus.write = 1'b0;
        #1;
        check_eq("abort_wait0", {31'b0, bus.waitrequest}, 32'h0);
        repeat (2) @(negedge clk);
        m_read("abort_mem", 32'h30);

        // Loader activity while a read is pending.
        @(negedge clk);
        bus.address = 32'h20; bus.read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inst_input = 1'b1; inst_addr = 8'h20; instruction = 32'hCAFEF00D;
        mem_m[8] = 32'hCAFEF00D;
        #1;
        check_eq("stall_0", {31'b0, bus.waitrequest}, 32'h1);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_n", {31'b0, bus.waitrequest}, 32'h1);
        end
        inst_input = 1'b0;
        wait_done(r, e);
        check_eq("stall_rd", r, 32'hCAFEF00D);
        check_eq("stall_lat", e, RW + 1);
        @(negedge clk);
        bus.read = 1'b0;
        rd_last = 32'hCAFEF00D;

        // Asynchronous reset in the middle of a waiting write.
        m_read("pre_rst", 32'h04);
        @(negedge clk);
        bus.address = 32'h40; bus.writedata = 32'h12345678;
        bus.byteenable = 4'hF; bus.write = 1'b1;
        @(posedge clk);
        #2;
        check_eq("mid_wait", {31'b0, bus.waitrequest}, 32'h1);
        RAM_Reset = 1'b0;
        #1;
        check_eq("arst_wait", {31'b0, bus.waitrequest}, 32'h0);
        check_eq("arst_rdata", bus.readdata, 32'h0);
        bus.write = 1'b0;
        model_clear();
        @(negedge clk);
        RAM_Reset = 1'b1;
        m_read("post_rst_04", 32'h04);
        m_read("post_rst_14", 32'h14);
        m_read("post_rst_40", 32'h40);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 120; t++) begin
            op = $urandom_range(0, 9);
            a  = {$urandom_range(0, 255) << 24, 14'h0, $urandom_range(0, 1023)};
            if (op <= 3) begin
                m_write(a, $urandom, 4'($urandom_range(0, 15)));
            end else if (op <= 7) begin
                m_read("rnd_rd", a);
            end else if (op == 8) begin
                m_rdwr(a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                for (int i = 0; i < 4; i++) begin
                    la[i] = 8'($urandom_range(0, 255));
                    ld[i] = $urandom;
                end
                load_seq($urandom_range(1, 4), la, ld);
            end
        end
        for (int i = 0; i < 16; i++) begin
            m_read("final_sweep", 32'(i * 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
